display_queue: RTL

DISPLAY_QUEUE -- requirements
Module: display_queue

---
 rtl/display_queue_if.sv | 22 ++
 rtl/display_queue.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/display_queue_if.sv
// display_queue_if: CPU-side store channel into the display queue.
//   wr_en    - CPU store to the display I/O address this cycle
//   wr_data  - byte stored by the CPU
//   wr_ready - queue can accept a store this cycle (not full)
// master: the CPU/store source; slave: the display queue.
interface display_queue_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_en,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/display_queue.sv
// display_queue: buffers CPU stores to the display address and presents each
// value on byt for at least HOLD_CYCLES clocks, in write order, back to back.
// Ports:
//   CLK      - system clock, rising edge
//   RST_N    - synchronous active-low reset
//   wr       - store channel (display_queue_if.slave: wr_en, wr_data, wr_ready)
//   byt      - value shown on the 7-segment stage ([7:4] tens, [3:0] ones)
//   busy     - a value is being held or entries are pending
//   overflow - sticky: a store arrived while the queue was full
module display_queue #(
  parameter int HOLD_CYCLES = 2000000,
  parameter int DEPTH       = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  display_queue_if.slave    wr,
  output logic [7:0]        byt,
  output logic              busy,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] RELOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT = (AW + 1)'(0);
  localparam logic [CW-1:0] ZERO_HLD = CW'(0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      byt_q, byt_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            wr_ready_q, wr_ready_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;

  logic            push_s;
  logic            pop_s;
  logic            empty_s;

  // Next-state logic: hold FSM, queue pointers/occupancy and status flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byt_d      = byt_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop_s      = 1'b0;

    empty_s = (count_q == ZERO_CNT);
    // wr_ready_q already means "not full"; gating on the registered flag keeps
    // a same-cycle pop from opening a slot for a same-cycle push.
    push_s  = wr.wr_en & wr_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          byt_d   = mem_q[rd_ptr_q];
          cnt_d   = RELOAD;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_q != ZERO_HLD) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!empty_s) begin
          // Hold expired with work pending: next value starts with no gap.
          pop_s   = 1'b1;
          byt_d   = mem_q[rd_ptr_q];
          cnt_d   = RELOAD;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO_HLD;
      end
    endcase

    if (push_s) begin
      mem_d[wr_ptr_q] = wr.wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (wr.wr_en && !wr_ready_q) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    wr_ready_d = (count_d != FULL_CNT);
    busy_d     = (state_d == ST_HOLD) || (count_d != ZERO_CNT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= ZERO_HLD;
      byt_q      <= 8'h00;
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      count_q    <= ZERO_CNT;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byt_q      <= byt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign wr.wr_ready = wr_ready_q;
  assign byt         = byt_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;

endmodule
